// File: rtl/x_feed_pkg.sv
// Shared types and constants for the multi-lane X feed buffer.
// Skewed draining is enabled by defining X_FEED_SKEW_EN.
package x_feed_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 32;
    localparam int LANES_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/x_skew_delay.sv
// Data+valid register pipeline of STAGES stages; STAGES=0 is a pass-through.
// Used per lane to place rows on the systolic diagonal wavefront.
module x_skew_delay #(
    parameter int DATA_W = 16,
    parameter int STAGES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unusedClkRst;
            assign unusedClkRst = clk_i ^ rst_i;
            assign data_o  = data_i;
            assign valid_o = valid_i;
        end else begin : g_pipe
            logic [DATA_W-1:0] dataQ [STAGES];
            logic [STAGES-1:0] validQ;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int s = 0; s < STAGES; s++) begin
                        dataQ[s] <= '0;
                    end
                    validQ <= '0;
                end else begin
                    dataQ[0]  <= data_i;
                    validQ[0] <= valid_i;
                    for (int s = 1; s < STAGES; s++) begin
                        dataQ[s]  <= dataQ[s-1];
                        validQ[s] <= validQ[s-1];
                    end
                end
            end

            assign data_o  = dataQ[STAGES-1];
            assign valid_o = validQ[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/x_feed_buffer.sv
// Multi-lane X feed buffer: random-access load, lock-step drain with START/DONE.
// Define X_FEED_SKEW_EN to delay lane k by k cycles (diagonal wavefront).
module x_feed_buffer
    import x_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WR_EN,
    input  logic [clog2w(LANES)-1:0]    WR_LANE,
    input  logic [$clog2(DEPTH)-1:0]    WR_IDX,
    input  logic [DATA_W-1:0]           WR_DATA,
    input  logic                        START,
    input  logic [$clog2(DEPTH):0]      LEN,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        WR_DROP,
    output logic [LANES*DATA_W-1:0]     DOUT,
    output logic [LANES-1:0]            DOUT_VALID
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = clog2w(LANES);
`ifdef X_FEED_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif
    localparam bit USE_FLUSH = SKEW_EN && (LANES > 1);

    state_t                  stateQ, stateD;
    logic [CW-1:0]           cntQ, cntD;
    logic [FW-1:0]           flushQ, flushD;
    logic [CW-1:0]           lenClamped;
    logic                    writeEn;
    logic                    shiftEn;
    logic                    wrDropQ;
    logic [DATA_W-1:0]       memQ [LANES][DEPTH];
    logic [LANES*DATA_W-1:0] stageDataQ;
    logic                    stageValidQ;
    logic [DATA_W-1:0]       laneData [LANES];
    logic [LANES-1:0]        laneValid;

    assign lenClamped = (LEN > CW'(DEPTH)) ? CW'(DEPTH) : LEN;
    assign writeEn    = (stateQ == IDLE) && WR_EN
                        && (int'(WR_LANE) < LANES) && (int'(WR_IDX) < DEPTH);
    // The extra DRAIN cycle with the counter at zero lines DONE up one cycle after the last beat.
    assign shiftEn    = (stateQ == DRAIN) && (cntQ != '0);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        flushD = flushQ;
        case (stateQ)
            IDLE: begin
                if (START) begin
                    if (lenClamped == '0) begin
                        stateD = FIN;
                    end else begin
                        stateD = DRAIN;
                        cntD   = lenClamped;
                    end
                end
            end
            DRAIN: begin
                if (cntQ != '0) begin
                    cntD = cntQ - CW'(1);
                end else if (USE_FLUSH) begin
                    stateD = FLUSH;
                    flushD = FW'(LANES - 1);
                end else begin
                    stateD = FIN;
                end
            end
            FLUSH: begin
                if (flushQ <= FW'(1)) begin
                    stateD = FIN;
                    flushD = '0;
                end else begin
                    flushD = flushQ - FW'(1);
                end
            end
            FIN:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            flushQ  <= '0;
            wrDropQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            flushQ  <= flushD;
            wrDropQ <= WR_EN && (stateQ != IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < LANES; k++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    memQ[k][j] <= '0;
                end
            end
        end else if (writeEn) begin
            memQ[WR_LANE][WR_IDX] <= WR_DATA;
        end else if (shiftEn) begin
            for (int k = 0; k < LANES; k++) begin
                for (int j = 0; j < DEPTH - 1; j++) begin
                    memQ[k][j] <= memQ[k][j+1];
                end
                memQ[k][DEPTH-1] <= '0;
            end
        end
    end

    // Output stage holds zero whenever it is not carrying a valid beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stageDataQ  <= '0;
            stageValidQ <= 1'b0;
        end else begin
            stageValidQ <= shiftEn;
            for (int k = 0; k < LANES; k++) begin
                stageDataQ[k*DATA_W +: DATA_W] <= shiftEn ? memQ[k][0] : '0;
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            x_skew_delay #(
                .DATA_W (DATA_W),
                .STAGES (SKEW_EN ? k : 0)
            ) u_delay (
                .clk_i   (CLK),
                .rst_i   (RST),
                .data_i  (stageDataQ[k*DATA_W +: DATA_W]),
                .valid_i (stageValidQ),
                .data_o  (laneData[k]),
                .valid_o (laneValid[k])
            );
            assign DOUT[k*DATA_W +: DATA_W] = laneValid[k] ? laneData[k] : '0;
        end
    endgenerate

    assign DOUT_VALID = laneValid;
    assign BUSY       = (stateQ != IDLE);
    assign DONE       = (stateQ == FIN);
    assign WR_DROP    = wrDropQ;

endmodule

// File: tb/tb_x_feed_buffer.sv
// Randomized self-checking bench for x_feed_buffer against a per-cycle timing model.
// Follows X_FEED_SKEW_EN to pick the skewed or aligned expectation.
module tb_x_feed_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int LANES  = 4;
    localparam int LW     = 2;
    localparam int IW     = 5;
    localparam int CW     = 6;
`ifdef X_FEED_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic                    CLK;
    logic                    RST;
    logic                    WR_EN;
    logic [LW-1:0]           WR_LANE;
    logic [IW-1:0]           WR_IDX;
    logic [DATA_W-1:0]       WR_DATA;
    logic                    START;
    logic [CW-1:0]           LEN;
    logic                    BUSY;
    logic                    DONE;
    logic                    WR_DROP;
    logic [LANES*DATA_W-1:0] DOUT;
    logic [LANES-1:0]        DOUT_VALID;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [LANES][DEPTH];
    logic [DATA_W-1:0] snap  [LANES][DEPTH];

    x_feed_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_LANE    (WR_LANE),
        .WR_IDX     (WR_IDX),
        .WR_DATA    (WR_DATA),
        .START      (START),
        .LEN        (LEN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WR_DROP    (WR_DROP),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearModel();
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < DEPTH; j++)
                model[k][j] = '0;
    endtask

    task automatic writeEntry(input int lane, input int idx, input logic [DATA_W-1:0] data);
        WR_EN   = 1'b1;
        WR_LANE = LW'(lane);
        WR_IDX  = IW'(idx);
        WR_DATA = data;
        tick();
        WR_EN = 1'b0;
        if (lane < LANES && idx < DEPTH) model[lane][idx] = data;
    endtask

    task automatic fillRandom();
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < DEPTH; j++)
                writeEntry(k, j, DATA_W'($urandom));
    endtask

    // Drain of len elements, START in cycle 0; optional hazards injected mid-drain.
    task automatic runDrain(input int len, input bit injectWr, input bit injectStart,
                            input bit wrAtStart, input logic [DATA_W-1:0] wrVal);
        int L, doneCyc, ofs;
        logic [LANES*DATA_W-1:0] expD;
        logic [LANES-1:0]        expV;
        logic                    expDone, expBusy, expDrop;
        if (wrAtStart) begin
            WR_EN = 1'b1; WR_LANE = '0; WR_IDX = '0; WR_DATA = wrVal;
            model[0][0] = wrVal;
        end
        START = 1'b1;
        LEN   = CW'(len);
        L = (len > DEPTH) ? DEPTH : len;
        doneCyc = (L == 0) ? 1 : L + 2 + ((SKEW && LANES > 1) ? LANES - 1 : 0);
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < DEPTH; j++)
                snap[k][j] = model[k][j];
        tick();
        START = 1'b0;
        WR_EN = 1'b0;
        for (int c = 1; c <= doneCyc + 1; c++) begin
            expD = '0;
            expV = '0;
            for (int k = 0; k < LANES; k++) begin
                ofs = c - 2 - (SKEW ? k : 0);
                if (ofs >= 0 && ofs < L) begin
                    expV[k] = 1'b1;
                    expD[k*DATA_W +: DATA_W] = snap[k][ofs];
                end
            end
            expDone = (c == doneCyc);
            expBusy = (c <= doneCyc);
            expDrop = injectWr && (c == 4);
            checks++;
            if (DOUT_VALID !== expV) begin
                failures++;
                $display("[TB] FAIL dout_valid len=%0d cycle=%0d got=%b exp=%b", len, c, DOUT_VALID, expV);
            end
            checks++;
            if (DOUT !== expD) begin
                failures++;
                $display("[TB] FAIL dout len=%0d cycle=%0d got=%h exp=%h", len, c, DOUT, expD);
            end
            checks++;
            if (DONE !== expDone) begin
                failures++;
                $display("[TB] FAIL done len=%0d cycle=%0d got=%b exp=%b", len, c, DONE, expDone);
            end
            checks++;
            if (BUSY !== expBusy) begin
                failures++;
                $display("[TB] FAIL busy len=%0d cycle=%0d got=%b exp=%b", len, c, BUSY, expBusy);
            end
            checks++;
            if (WR_DROP !== expDrop) begin
                failures++;
                $display("[TB] FAIL wr_drop len=%0d cycle=%0d got=%b exp=%b", len, c, WR_DROP, expDrop);
            end
            WR_EN = 1'b0;
            START = 1'b0;
            if (injectWr && c == 3) begin
                WR_EN   = 1'b1;
                WR_LANE = LW'($urandom_range(0, LANES - 1));
                WR_IDX  = IW'($urandom_range(0, DEPTH - 1));
                WR_DATA = DATA_W'($urandom);
            end
            if (injectStart && c == 2) begin
                START = 1'b1;
                LEN   = CW'(1);
            end
            tick();
        end
        WR_EN = 1'b0;
        START = 1'b0;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < DEPTH; j++)
                model[k][j] = (j + L < DEPTH) ? snap[k][j + L] : '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (DOUT !== '0 || DOUT_VALID !== '0 || BUSY !== 1'b0 || DONE !== 1'b0 || WR_DROP !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got dout=%h valid=%b busy=%b done=%b drop=%b exp all zero",
                     DOUT, DOUT_VALID, BUSY, DONE, WR_DROP);
        end
        RST = 1'b0;
        clearModel();
        tick();
    endtask

    task automatic test_basic();
        for (int j = 0; j < 4; j++) writeEntry(0, j, DATA_W'(j + 1));
        runDrain(4, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_skew_pattern();
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 4; j++)
                writeEntry(k, j, DATA_W'(16'h00A0 + j));
        runDrain(3, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_boundaries();
        runDrain(0, 1'b0, 1'b0, 1'b0, '0);
        fillRandom();
        runDrain(40, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_past_written();
        writeEntry($urandom_range(0, LANES - 1), 31, 16'hBEEF);
        runDrain(32, 1'b0, 1'b0, 1'b0, '0);
        runDrain(32, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_hazards();
        fillRandom();
        runDrain(6, 1'b1, 1'b1, 1'b0, '0);
        runDrain(32, 1'b0, 1'b0, 1'b0, '0);
        runDrain(2, 1'b0, 1'b0, 1'b1, 16'h5A5A);
    endtask

    task automatic test_reset_mid_drain();
        int sawDone;
        fillRandom();
        START = 1'b1;
        LEN   = CW'(8);
        tick();
        START = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (DOUT !== '0 || DOUT_VALID !== '0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_drain got dout=%h valid=%b busy=%b done=%b exp all zero",
                     DOUT, DOUT_VALID, BUSY, DONE);
        end
        sawDone = 0;
        for (int c = 0; c < 12; c++) begin
            if (DONE === 1'b1) sawDone++;
            tick();
        end
        checks++;
        if (sawDone != 0) begin
            failures++;
            $display("[TB] FAIL no_done_after_abort got=%0d exp=0", sawDone);
        end
        clearModel();
        runDrain(32, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 20; w++)
                writeEntry($urandom_range(0, LANES - 1), $urandom_range(0, DEPTH - 1), DATA_W'($urandom));
            runDrain($urandom_range(0, 40), 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        RST = 1'b1; WR_EN = 1'b0; WR_LANE = '0; WR_IDX = '0; WR_DATA = '0;
        START = 1'b0; LEN = '0;
        test_reset();
        test_basic();
        test_skew_pattern();
        test_boundaries();
        test_past_written();
        test_hazards();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
